cv32e40x_ex_result_join: RTL and testbench

CV32E40X_EX_RESULT_JOIN -- requirements
Module: cv32e40x_ex_result_join

---
 rtl/cv32e40x_ex_result_join_if.sv | 44 ++++
 rtl/cv32e40x_ex_result_join.sv | 181 ++++++++++++++++++
 tb/tb_cv32e40x_ex_result_join.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_ex_result_join_if.sv
// Handshake and data bundle between the EX stage, its functional units and WB.
// The master modport is the environment around the join block; slave is the join block.
interface cv32e40x_ex_result_join_if #(
  parameter int unsigned NUM_FU      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STALL_CNT_W = 16
);
  logic                     instr_valid_i;
  logic [NUM_FU-1:0]        fu_sel_i;
  logic [NUM_FU-1:0]        fu_valid_i;
  logic [NUM_FU*DATA_W-1:0] fu_data_i;
  logic [NUM_FU-1:0]        fu_ready_o;
  logic                     rf_we_i;
  logic [ADDR_W-1:0]        rf_waddr_i;
  logic [31:0]              pc_i;
  logic                     exc_i;
  logic                     kill_i;
  logic                     halt_i;
  logic                     ex_ready_o;
  logic                     ex_valid_o;
  logic                     wb_valid_o;
  logic                     wb_rf_we_o;
  logic [ADDR_W-1:0]        wb_rf_waddr_o;
  logic [DATA_W-1:0]        wb_rf_wdata_o;
  logic [31:0]              wb_pc_o;
  logic                     wb_exc_o;
  logic                     wb_ready_i;
  logic [STALL_CNT_W-1:0]   stall_cnt_o;

  modport master (
    output instr_valid_i, fu_sel_i, fu_valid_i, fu_data_i, rf_we_i, rf_waddr_i, pc_i,
           exc_i, kill_i, halt_i, wb_ready_i,
    input  fu_ready_o, ex_ready_o, ex_valid_o, wb_valid_o, wb_rf_we_o, wb_rf_waddr_o,
           wb_rf_wdata_o, wb_pc_o, wb_exc_o, stall_cnt_o
  );

  modport slave (
    input  instr_valid_i, fu_sel_i, fu_valid_i, fu_data_i, rf_we_i, rf_waddr_i, pc_i,
           exc_i, kill_i, halt_i, wb_ready_i,
    output fu_ready_o, ex_ready_o, ex_valid_o, wb_valid_o, wb_rf_we_o, wb_rf_waddr_o,
           wb_rf_wdata_o, wb_pc_o, wb_exc_o, stall_cnt_o
  );
endinterface

// File: rtl/cv32e40x_ex_result_join.sv
// EX result join: picks the selected functional unit's result, hands it to the WB output
// register and counts stall cycles. Define CV32E40X_EX_SKID_EN to add a one-entry skid
// register beside the output register, which cuts the wb_ready_i -> ex_ready_o path.
module cv32e40x_ex_result_join #(
  parameter int unsigned NUM_FU      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic                      clk,
  input logic                      rst,
  cv32e40x_ex_result_join_if.slave bus
);

  logic              instr_ok;
  logic              ex_valid;
  logic              out_ready;
  logic              transfer;
  logic [DATA_W-1:0] sel_data;

  logic              out_valid_q, out_valid_d;
  logic              out_we_q, out_we_d;
  logic              out_exc_q, out_exc_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [31:0]       out_pc_q, out_pc_d;

`ifdef CV32E40X_EX_SKID_EN
  // Skid keeps the raw rf_we so addr/data follow the same hold rule when promoted
  logic              skid_valid_q, skid_valid_d;
  logic              skid_we_q, skid_we_d;
  logic              skid_exc_q, skid_exc_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [31:0]       skid_pc_q, skid_pc_d;
`endif

  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Lowest-index selected unit supplies the result; no selection gives zero
  always_comb begin
    sel_data = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (bus.fu_sel_i[k]) begin
        sel_data = bus.fu_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign instr_ok = bus.instr_valid_i & ~bus.kill_i & ~bus.halt_i;
  assign ex_valid = instr_ok & ((|(bus.fu_sel_i & bus.fu_valid_i)) | bus.exc_i);

`ifdef CV32E40X_EX_SKID_EN
  assign out_ready = ~skid_valid_q;
`else
  assign out_ready = bus.wb_ready_i | ~out_valid_q;
`endif

  assign transfer       = ex_valid & out_ready;
  assign bus.ex_valid_o = ex_valid;
  assign bus.ex_ready_o = bus.kill_i | (out_ready & ~bus.halt_i);
  assign bus.fu_ready_o = bus.fu_sel_i & {NUM_FU{out_ready & ~bus.halt_i}};

  // Output register (and skid) next state: load on transfer, bubble when drained, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_we_d    = out_we_q;
    out_exc_d   = out_exc_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
`ifdef CV32E40X_EX_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_we_d    = skid_we_q;
    skid_exc_d   = skid_exc_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    if (out_valid_q && !bus.wb_ready_i) begin
      // WB stalled: a new result parks in the skid, the output register holds
      if (transfer) begin
        skid_valid_d = 1'b1;
        skid_we_d    = bus.rf_we_i;
        skid_exc_d   = bus.exc_i;
        skid_addr_d  = bus.rf_waddr_i;
        skid_data_d  = sel_data;
        skid_pc_d    = bus.pc_i;
      end
    end else if (skid_valid_q) begin
      // Older skid entry goes first; out_ready is low so nothing new arrives this cycle
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b1;
      out_exc_d    = skid_exc_q;
      out_pc_d     = skid_pc_q;
      out_we_d     = skid_we_q & ~skid_exc_q;
      if (skid_we_q) begin
        out_addr_d = skid_addr_q;
        out_data_d = skid_data_q;
      end
    end else if (transfer) begin
      out_valid_d = 1'b1;
      out_exc_d   = bus.exc_i;
      out_pc_d    = bus.pc_i;
      out_we_d    = bus.rf_we_i & ~bus.exc_i;
      if (bus.rf_we_i) begin
        out_addr_d = bus.rf_waddr_i;
        out_data_d = sel_data;
      end
    end else if (bus.wb_ready_i) begin
      out_valid_d = 1'b0;
    end
`else
    if (transfer) begin
      out_valid_d = 1'b1;
      out_exc_d   = bus.exc_i;
      out_pc_d    = bus.pc_i;
      out_we_d    = bus.rf_we_i & ~bus.exc_i;
      if (bus.rf_we_i) begin
        out_addr_d = bus.rf_waddr_i;
        out_data_d = sel_data;
      end
    end else if (bus.wb_ready_i) begin
      out_valid_d = 1'b0;
    end
`endif
  end

  // Saturating stall counter: a live instruction that did not move this cycle
  always_comb begin
    stall_d = stall_q;
    if (bus.instr_valid_i && !bus.kill_i && !transfer && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_we_q     <= 1'b0;
      out_exc_q    <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_pc_q     <= '0;
`ifdef CV32E40X_EX_SKID_EN
      skid_valid_q <= 1'b0;
      skid_we_q    <= 1'b0;
      skid_exc_q   <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
`endif
      stall_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_we_q     <= out_we_d;
      out_exc_q    <= out_exc_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
`ifdef CV32E40X_EX_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_we_q    <= skid_we_d;
      skid_exc_q   <= skid_exc_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
`endif
      stall_q      <= stall_d;
    end
  end

  assign bus.wb_valid_o    = out_valid_q;
  assign bus.wb_rf_we_o    = out_we_q;
  assign bus.wb_exc_o      = out_exc_q;
  assign bus.wb_rf_waddr_o = out_addr_q;
  assign bus.wb_rf_wdata_o = out_data_q;
  assign bus.wb_pc_o       = out_pc_q;
  assign bus.stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_cv32e40x_ex_result_join.sv
// Bench for cv32e40x_ex_result_join: vector table, hand sequences, then random traffic
// checked against a queue-based model of the WB side.
module tb_cv32e40x_ex_result_join;
  localparam int unsigned NumFu = 4;
  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = 16;
`ifdef CV32E40X_EX_SKID_EN
  localparam int unsigned Cap = 2;
`else
  localparam int unsigned Cap = 1;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cv32e40x_ex_result_join_if #(.NUM_FU(NumFu), .DATA_W(DataW), .ADDR_W(AddrW),
                               .STALL_CNT_W(CntW)) bus ();
  cv32e40x_ex_result_join_if #(.NUM_FU(NumFu), .DATA_W(DataW), .ADDR_W(AddrW),
                               .STALL_CNT_W(2)) bus2 ();

  cv32e40x_ex_result_join #(.NUM_FU(NumFu), .DATA_W(DataW), .ADDR_W(AddrW),
                            .STALL_CNT_W(CntW)) dut (.clk(clk), .rst(rst), .bus(bus));
  cv32e40x_ex_result_join #(.NUM_FU(NumFu), .DATA_W(DataW), .ADDR_W(AddrW),
                            .STALL_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: WB side as a FIFO of Cap entries ----------------
  typedef struct packed {
    logic        we_raw;
    logic        exc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_we, m_exc;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_pc;
  logic [15:0] m_stall;

  function automatic logic m_out_ready();
    return (mq.size() < Cap) || (Cap == 1 && bus.wb_ready_i);
  endfunction

  function automatic logic m_ex_valid();
    return bus.instr_valid_i && !bus.kill_i && !bus.halt_i &&
           ((|(bus.fu_sel_i & bus.fu_valid_i)) || bus.exc_i);
  endfunction

  function automatic ent_t m_entry();
    ent_t e;
    e.we_raw = bus.rf_we_i;
    e.exc    = bus.exc_i;
    e.addr   = bus.rf_waddr_i;
    e.pc     = bus.pc_i;
    e.data   = '0;
    for (int k = 0; k < NumFu; k++) begin
      if (bus.fu_sel_i[k]) begin
        e.data = bus.fu_data_i[k*32 +: 32];
        break;
      end
    end
    return e;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_we = 0; m_exc = 0; m_addr = '0; m_data = '0; m_pc = '0; m_stall = '0;
  endtask

  task automatic model_update();
    logic xfer, popped, was_empty;
    ent_t h;
    if (rst) begin
      m_reset();
      return;
    end
    xfer = m_ex_valid() && m_out_ready();
    if (xfer && !$onehot0(bus.fu_sel_i)) begin
      errors++;
      $display("FAIL multi_sel: fu_sel_i=%b has more than one unit", bus.fu_sel_i);
    end
    if (bus.instr_valid_i && !bus.kill_i && !xfer && m_stall != 16'hFFFF) m_stall++;
    was_empty = (mq.size() == 0);
    popped = 0;
    if (bus.wb_ready_i && mq.size() > 0) begin
      void'(mq.pop_front());
      popped = 1;
    end
    if (xfer) mq.push_back(m_entry());
    if ((popped || (was_empty && xfer)) && mq.size() > 0) begin
      h = mq[0];
      m_pc  = h.pc;
      m_exc = h.exc;
      m_we  = h.we_raw & ~h.exc;
      if (h.we_raw) begin
        m_addr = h.addr;
        m_data = h.data;
      end
    end
  endtask

  task automatic check_model();
    logic ok;
    ok = m_out_ready();
    chk("ex_valid", 128'(bus.ex_valid_o), 128'(m_ex_valid()));
    chk("ex_ready", 128'(bus.ex_ready_o), 128'(bus.kill_i | (ok & ~bus.halt_i)));
    chk("fu_ready", 128'(bus.fu_ready_o), 128'(bus.fu_sel_i & {NumFu{ok & ~bus.halt_i}}));
    chk("wb_valid", 128'(bus.wb_valid_o), 128'(mq.size() != 0));
    chk("wb_payload", 128'({bus.wb_rf_we_o, bus.wb_exc_o, bus.wb_rf_waddr_o,
                            bus.wb_rf_wdata_o, bus.wb_pc_o}),
        128'({m_we, m_exc, m_addr, m_data, m_pc}));
    chk("stall_cnt", 128'(bus.stall_cnt_o), 128'(m_stall));
  endtask

  // Inputs are driven at the falling edge; outputs are compared 1 time unit later
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.instr_valid_i = 0; bus.fu_sel_i = '0; bus.fu_valid_i = '0; bus.fu_data_i = '0;
    bus.rf_we_i = 0; bus.rf_waddr_i = '0; bus.pc_i = '0; bus.exc_i = 0;
    bus.kill_i = 0; bus.halt_i = 0; bus.wb_ready_i = 1;
  endtask

  task automatic instr(input int u, input logic [31:0] pc, input logic [4:0] wa,
                       input logic [31:0] d);
    bus.instr_valid_i = 1; bus.fu_sel_i = 4'(1 << u); bus.fu_valid_i = 4'(1 << u);
    bus.fu_data_i = '0; bus.fu_data_i[u*32 +: 32] = d;
    bus.rf_we_i = 1; bus.rf_waddr_i = wa; bus.pc_i = pc;
    bus.exc_i = 0; bus.kill_i = 0; bus.halt_i = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic iv; logic [3:0] sel, val; logic [127:0] data; logic we; logic [4:0] wa;
    logic [31:0] pc; logic exc, kill, halt;
    logic e_ev, e_er; logic [3:0] e_fr; logic e_wv, e_we, e_exc; logic [4:0] e_addr;
    logic [31:0] e_data, e_pc; logic e_st;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [3:0] sel, logic [3:0] val, logic [127:0] data,
                              logic we, logic [4:0] wa, logic [31:0] pc, logic exc,
                              logic kill, logic halt, logic e_ev, logic e_er, logic [3:0] e_fr,
                              logic e_wv, logic e_we, logic e_exc, logic [4:0] e_addr,
                              logic [31:0] e_data, logic [31:0] e_pc, logic e_st);
    vec_t v;
    v.iv = iv; v.sel = sel; v.val = val; v.data = data; v.we = we; v.wa = wa; v.pc = pc;
    v.exc = exc; v.kill = kill; v.halt = halt; v.e_ev = e_ev; v.e_er = e_er; v.e_fr = e_fr;
    v.e_wv = e_wv; v.e_we = e_we; v.e_exc = e_exc; v.e_addr = e_addr; v.e_data = e_data;
    v.e_pc = e_pc; v.e_st = e_st;
    return v;
  endfunction

  vec_t        vt[9];
  logic [15:0] exp_stall;
  logic [15:0] base;

  initial begin
    vt[0] = mk(1, 4'b0100, 4'b0100, {32'h0, 32'hDEADBEEF, 64'h0}, 1, 7, 32'h100, 0, 0, 0,
               1, 1, 4'b0100, 1, 1, 0, 7, 32'hDEADBEEF, 32'h100, 0);
    vt[1] = mk(1, 4'b0000, 4'b0000, 128'h0, 1, 3, 32'h104, 1, 0, 0,
               1, 1, 4'b0000, 1, 0, 1, 3, 32'h0, 32'h104, 0);
    vt[2] = mk(1, 4'b0001, 4'b0001, {96'h0, 32'h11111111}, 1, 12, 32'h108, 0, 1, 0,
               0, 1, 4'b0001, 0, 0, 1, 3, 32'h0, 32'h104, 0);
    vt[3] = mk(1, 4'b0010, 4'b0010, {64'h0, 32'h22222222, 32'h0}, 1, 13, 32'h10C, 0, 0, 1,
               0, 0, 4'b0000, 0, 0, 1, 3, 32'h0, 32'h104, 1);
    vt[4] = mk(1, 4'b1000, 4'b0111, {32'h33333333, 96'h0}, 1, 14, 32'h110, 0, 0, 0,
               0, 1, 4'b1000, 0, 0, 1, 3, 32'h0, 32'h104, 1);
    vt[5] = mk(1, 4'b0000, 4'b1111, 128'h0, 1, 15, 32'h114, 0, 0, 0,
               0, 1, 4'b0000, 0, 0, 1, 3, 32'h0, 32'h104, 1);
    vt[6] = mk(0, 4'b0001, 4'b0001, {96'h0, 32'h44444444}, 1, 16, 32'h118, 0, 0, 0,
               0, 1, 4'b0001, 0, 0, 1, 3, 32'h0, 32'h104, 0);
    vt[7] = mk(1, 4'b0001, 4'b0001, {96'h0, 32'h12345678}, 0, 9, 32'h11C, 0, 0, 0,
               1, 1, 4'b0001, 1, 0, 0, 3, 32'h0, 32'h11C, 0);
    vt[8] = mk(1, 4'b1000, 4'b1000, {32'hCAFEF00D, 96'h0}, 1, 31, 32'h120, 0, 0, 0,
               1, 1, 4'b1000, 1, 1, 0, 31, 32'hCAFEF00D, 32'h120, 0);

    // ---- reset: registers start undefined, so the first edge is not compared ----
    idle();
    bus2.instr_valid_i = 0; bus2.fu_sel_i = '0; bus2.fu_valid_i = '0; bus2.fu_data_i = '0;
    bus2.rf_we_i = 0; bus2.rf_waddr_i = '0; bus2.pc_i = '0; bus2.exc_i = 0;
    bus2.kill_i = 0; bus2.halt_i = 0; bus2.wb_ready_i = 1;
    rst = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    instr(0, 32'h50, 1, 32'h5); // combinational outputs still follow inputs in reset
    step();
    idle();
    rst = 0;
    #1;
    chk("rst_wb_valid", 128'(bus.wb_valid_o), 128'(0));
    chk("rst_wb_flags", 128'({bus.wb_rf_we_o, bus.wb_exc_o}), 128'(0));
    chk("rst_wb_payload", 128'({bus.wb_rf_waddr_o, bus.wb_rf_wdata_o, bus.wb_pc_o}), 128'(0));
    chk("rst_stall", 128'(bus.stall_cnt_o), 128'(0));

    // ---- narrow counter saturates instead of wrapping ----
    bus2.instr_valid_i = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      #1;
      if (c == 1) chk("sat_cnt_2", 128'(bus2.stall_cnt_o), 128'(2));
      if (c >= 2) chk($sformatf("sat_cnt_%0d", c + 1), 128'(bus2.stall_cnt_o), 128'(3));
    end
    bus2.instr_valid_i = 0;

    // ---- vector table, WB always ready ----
    exp_stall = '0;
    for (int i = 0; i < 9; i++) begin
      bus.instr_valid_i = vt[i].iv; bus.fu_sel_i = vt[i].sel; bus.fu_valid_i = vt[i].val;
      bus.fu_data_i = vt[i].data; bus.rf_we_i = vt[i].we; bus.rf_waddr_i = vt[i].wa;
      bus.pc_i = vt[i].pc; bus.exc_i = vt[i].exc; bus.kill_i = vt[i].kill;
      bus.halt_i = vt[i].halt; bus.wb_ready_i = 1;
      #1;
      chk($sformatf("tv%0d_ex_valid", i), 128'(bus.ex_valid_o), 128'(vt[i].e_ev));
      chk($sformatf("tv%0d_ex_ready", i), 128'(bus.ex_ready_o), 128'(vt[i].e_er));
      chk($sformatf("tv%0d_fu_ready", i), 128'(bus.fu_ready_o), 128'(vt[i].e_fr));
      step();
      if (vt[i].e_st) exp_stall++;
      #1;
      chk($sformatf("tv%0d_wb_valid", i), 128'(bus.wb_valid_o), 128'(vt[i].e_wv));
      chk($sformatf("tv%0d_wb_flags", i), 128'({bus.wb_rf_we_o, bus.wb_exc_o}),
          128'({vt[i].e_we, vt[i].e_exc}));
      chk($sformatf("tv%0d_wb_addr_data", i), 128'({bus.wb_rf_waddr_o, bus.wb_rf_wdata_o}),
          128'({vt[i].e_addr, vt[i].e_data}));
      chk($sformatf("tv%0d_wb_pc", i), 128'(bus.wb_pc_o), 128'(vt[i].e_pc));
      chk($sformatf("tv%0d_stall", i), 128'(bus.stall_cnt_o), 128'(exp_stall));
    end

    // ---- WB stalled for 3 cycles with instruction B pending ----
    idle();
    step();
    instr(1, 32'h200, 4, 32'hA0A0A0A0);
    step();
    instr(1, 32'h204, 5, 32'hB0B0B0B0);
    bus.wb_ready_i = 0;
    base = m_stall;
    for (int c = 0; c < 3; c++) begin
      #1;
`ifdef CV32E40X_EX_SKID_EN
      chk($sformatf("wbstall_ex_ready_c%0d", c + 1), 128'(bus.ex_ready_o), 128'(c == 0));
`else
      chk($sformatf("wbstall_ex_ready_c%0d", c + 1), 128'(bus.ex_ready_o), 128'(0));
`endif
      step();
    end
    #1;
    chk("wbstall_a_held", 128'({bus.wb_valid_o, bus.wb_pc_o}), 128'({1'b1, 32'h200}));
    chk("wbstall_cnt", 128'(bus.stall_cnt_o), 128'(base + 16'(Cap == 1 ? 3 : 2)));
    bus.wb_ready_i = 1;
    step();
    #1;
    chk("wbstall_b_out", 128'({bus.wb_valid_o, bus.wb_pc_o, bus.wb_rf_wdata_o}),
        128'({1'b1, 32'h204, 32'hB0B0B0B0}));
    idle();
    step();
    step();

    // ---- reset while output (and skid, if present) are full ----
    instr(2, 32'h300, 6, 32'h3000);
    step();
    instr(3, 32'h304, 8, 32'h3040);
    bus.wb_ready_i = 0;
    step();
    idle();
    bus.wb_ready_i = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("midrst_wb", 128'({bus.wb_valid_o, bus.wb_rf_we_o, bus.wb_exc_o}), 128'(0));
    chk("midrst_payload", 128'({bus.wb_rf_waddr_o, bus.wb_rf_wdata_o, bus.wb_pc_o}), 128'(0));
    chk("midrst_stall", 128'(bus.stall_cnt_o), 128'(0));
    bus.wb_ready_i = 1;
    step();
    #1;
    chk("midrst_no_leak", 128'(bus.wb_valid_o), 128'(0));

    // ---- random traffic against the model ----
    for (int n = 0; n < 800; n++) begin
      int u;
      u = int'($urandom_range(0, NumFu));
      bus.instr_valid_i = ($urandom_range(0, 3) != 0);
      bus.fu_sel_i      = (u == int'(NumFu)) ? 4'b0000 : 4'(1 << u);
      bus.fu_valid_i    = 4'($urandom);
      bus.fu_data_i     = {$urandom, $urandom, $urandom, $urandom};
      bus.rf_we_i       = $urandom_range(0, 1) == 1;
      bus.rf_waddr_i    = 5'($urandom);
      bus.pc_i          = $urandom;
      bus.exc_i         = ($urandom_range(0, 7) == 0);
      bus.kill_i        = ($urandom_range(0, 7) == 0);
      bus.halt_i        = ($urandom_range(0, 7) == 0);
      bus.wb_ready_i    = ($urandom_range(0, 3) != 0);
      rst               = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
